// File: rtl/nios_mult_pipe.sv
// nios_mult_pipe: two-stage pipelined WIDTH x WIDTH integer multiplier with a
// valid/ready handshake and a sideband tag.
// Stage 1 registers four half-width partial products and the sign flags.
// Stage 2 sums them, applies signed correction and drives the result.
// Optional feature macro: NIOS_MULT_PIPE_HI_EN. When it is defined, the upper
// product half (out_hi) is built with uu/su/ss modes. When it is undefined,
// out_hi is tied to 0, in_mode is ignored, and out_lo is bit-identical.
module nios_mult_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned DW   = 2 * WIDTH;

    // Pipeline advance: both stages move unless a held result is blocked
    logic w_adv;

    // Operand halves
    logic [HALF-1:0]  w_a_lo;
    logic [HALF-1:0]  w_a_hi;
    logic [HALF-1:0]  w_b_lo;
    logic [HALF-1:0]  w_b_hi;

    // Partial products (HALF x HALF unsigned, 2*HALF = WIDTH bits)
    logic [WIDTH-1:0] w_pp_ll;
    logic [WIDTH-1:0] w_pp_lh;
    logic [WIDTH-1:0] w_pp_hl;

    // Stage 1 registers
    logic [WIDTH-1:0] r_pp_ll;
    logic [WIDTH-1:0] r_pp_lh;
    logic [WIDTH-1:0] r_pp_hl;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_valid;

    // Stage 2 registers
    logic [WIDTH-1:0] r_out_lo;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_valid;

    // Low half of the final product, formed from stage 1 registers
    logic [WIDTH-1:0] w_lo;

    // A full result that the consumer refuses freezes the whole pipe
    assign w_adv    = !(r_out_valid && !out_ready);
    assign in_ready = w_adv;

    // Split operands into halves
    assign w_a_lo = in_a[HALF-1:0];
    assign w_a_hi = in_a[WIDTH-1:HALF];
    assign w_b_lo = in_b[HALF-1:0];
    assign w_b_hi = in_b[WIDTH-1:HALF];

    // Unsigned half-width partial products
    assign w_pp_ll = WIDTH'(w_a_lo) * WIDTH'(w_b_lo);
    assign w_pp_lh = WIDTH'(w_a_lo) * WIDTH'(w_b_hi);
    assign w_pp_hl = WIDTH'(w_a_hi) * WIDTH'(w_b_lo);

`ifdef NIOS_MULT_PIPE_HI_EN

    logic [WIDTH-1:0] w_pp_hh;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] r_pp_hh;
    logic             r_sa;
    logic             r_sb;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out_hi;
    logic [DW-1:0]    w_prod;

    // High x high partial product and operand sign flags (mode 10 acts as uu)
    assign w_pp_hh = WIDTH'(w_a_hi) * WIDTH'(w_b_hi);
    assign w_sa    = in_mode[0] & in_a[WIDTH-1];
    assign w_sb    = in_mode[1] & in_mode[0] & in_b[WIDTH-1];

    // Sum partial products, then subtract the two's-complement sign weights
    always_comb begin
        w_prod = DW'(r_pp_ll)
               + (DW'(r_pp_lh) << HALF)
               + (DW'(r_pp_hl) << HALF)
               + (DW'(r_pp_hh) << WIDTH);
        if (r_sa) begin
            w_prod = w_prod - {r_b, {WIDTH{1'b0}}};
        end
        if (r_sb) begin
            w_prod = w_prod - {r_a, {WIDTH{1'b0}}};
        end
    end

    assign w_lo = w_prod[WIDTH-1:0];

    // Upper-product stage 1 and stage 2 registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pp_hh  <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_out_hi <= '0;
        end else if (w_adv) begin
            r_pp_hh  <= w_pp_hh;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_a      <= in_a;
            r_b      <= in_b;
            r_out_hi <= w_prod[DW-1:WIDTH];
        end
    end

    assign out_hi = r_out_hi;

`else

    // Mode only affects the upper half, which is not built here
    logic [1:0] w_unused_mode;
    assign w_unused_mode = in_mode;

    // Low half only: terms shifted by WIDTH or more cannot reach it
    assign w_lo = r_pp_ll + (r_pp_lh << HALF) + (r_pp_hl << HALF);

    assign out_hi = '0;

`endif

    // Common pipeline registers: valid bits, tags, partial products, low result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pp_ll     <= '0;
            r_pp_lh     <= '0;
            r_pp_hl     <= '0;
            r_s1_tag    <= '0;
            r_s1_valid  <= 1'b0;
            r_out_lo    <= '0;
            r_out_tag   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_pp_ll     <= w_pp_ll;
            r_pp_lh     <= w_pp_lh;
            r_pp_hl     <= w_pp_hl;
            r_s1_tag    <= in_tag;
            r_s1_valid  <= in_valid;
            r_out_lo    <= w_lo;
            r_out_tag   <= r_s1_tag;
            r_out_valid <= r_s1_valid;
        end
    end

    assign out_valid = r_out_valid;
    assign out_lo    = r_out_lo;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_nios_mult_pipe.sv
// Directed bench for nios_mult_pipe: 32-bit corner vectors, streaming,
// backpressure, reset flush, and a 16-bit randomized sweep with a model.
// Expected upper halves follow NIOS_MULT_PIPE_HI_EN.
module tb_nios_mult_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // 32-bit instance
    logic        iv = 1'b0;
    logic        ir;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  mode = '0;
    logic [4:0]  tag = '0;
    logic        ov;
    logic        ordy = 1'b1;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [4:0]  otag;

    // 16-bit instance
    logic        s_iv = 1'b0;
    logic        s_ir;
    logic [15:0] s_a = '0;
    logic [15:0] s_b = '0;
    logic [1:0]  s_mode = '0;
    logic [4:0]  s_tag = '0;
    logic        s_ov;
    logic        s_ordy = 1'b1;
    logic [15:0] s_lo;
    logic [15:0] s_hi;
    logic [4:0]  s_otag;

    int n_total = 0;
    int n_bad   = 0;

    logic [36:0] q[$];
    logic [31:0] ea, eb, p;
    logic [36:0] front;

    always #5 clk = ~clk;

    nios_mult_pipe #(.WIDTH(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .reset(reset),
        .in_valid(iv), .in_ready(ir), .in_a(a), .in_b(b), .in_mode(mode), .in_tag(tag),
        .out_valid(ov), .out_ready(ordy), .out_lo(lo), .out_hi(hi), .out_tag(otag)
    );

    nios_mult_pipe #(.WIDTH(16), .TAG_W(5)) u_dut16 (
        .clk(clk), .reset(reset),
        .in_valid(s_iv), .in_ready(s_ir), .in_a(s_a), .in_b(s_b), .in_mode(s_mode), .in_tag(s_tag),
        .out_valid(s_ov), .out_ready(s_ordy), .out_lo(s_lo), .out_hi(s_hi), .out_tag(s_otag)
    );

    function automatic logic [31:0] eh32(input logic [31:0] v);
`ifdef NIOS_MULT_PIPE_HI_EN
        return v;
`else
        return 32'(v & 32'h0);
`endif
    endfunction

    function automatic logic [15:0] eh16(input logic [15:0] v);
`ifdef NIOS_MULT_PIPE_HI_EN
        return v;
`else
        return 16'(v & 16'h0);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One isolated operation: accept, check latency, check result, check drain
    task automatic one_op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [1:0] im, input logic [4:0] it,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        a = ia; b = ib; mode = im; tag = it; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        chk({name, "_lat1"}, 64'(ov), 64'd0);
        @(posedge clk); #1;
        chk({name, "_valid"}, 64'(ov), 64'd1);
        chk({name, "_lo"}, 64'(lo), 64'(exp_lo));
        chk({name, "_hi"}, 64'(hi), 64'(eh32(exp_hi)));
        chk({name, "_tag"}, 64'(otag), 64'(it));
        @(posedge clk); #1;
        chk({name, "_drain"}, 64'(ov), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_valid", 64'(ov), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_tag", 64'(otag), 64'd0);
        chk("rst_ready", 64'(ir), 64'd1);

        // Corner vectors
        one_op("uu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 5'd3, 32'h0000_0001, 32'hFFFF_FFFE);
        one_op("ss_m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 5'd4, 32'h0000_0001, 32'h0000_0000);
        one_op("su_m1x2", 32'hFFFF_FFFF, 32'h0000_0002, 2'b01, 5'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        one_op("m10_uu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 5'd6, 32'h0000_0001, 32'hFFFF_FFFE);
        one_op("ss_neg_pos", 32'hFFFF_FFFD, 32'h0000_0005, 2'b11, 5'd7, 32'hFFFF_FFF1, 32'hFFFF_FFFF);
        one_op("uu_cross", 32'h0001_0000, 32'h0001_0000, 2'b00, 5'd8, 32'h0000_0000, 32'h0000_0001);

        // Back-to-back stream of 8 operations
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 8) begin
                iv = 1'b1; a = 32'(cyc); b = 32'(cyc + 32'h1_0000); tag = 5'(cyc); mode = 2'b00;
            end else begin
                iv = 1'b0;
            end
            @(posedge clk); #1;
            chk("stream_valid", 64'(ov), 64'((cyc >= 1) && (cyc <= 8)));
            if (cyc >= 1 && cyc <= 8) begin
                chk("stream_lo", 64'(lo), 64'(32'((cyc - 1) * (cyc - 1) + ((cyc - 1) << 16))));
                chk("stream_hi", 64'(hi), 64'd0);
                chk("stream_tag", 64'(otag), 64'(cyc - 1));
            end
        end
        iv = 1'b0;

        // Backpressure with both stages full
        a = 32'd3; b = 32'd5; tag = 5'd10; mode = 2'b00; iv = 1'b1;
        @(posedge clk); #1;
        a = 32'd7; b = 32'd9; tag = 5'd11; ordy = 1'b0;
        @(posedge clk); #1;
        a = 32'd100; b = 32'd200; tag = 5'd12;
        chk("stall_ready0", 64'(ir), 64'd0);
        chk("stall_tag0", 64'(otag), 64'd10);
        chk("stall_lo0", 64'(lo), 64'd15);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stall_hold_valid", 64'(ov), 64'd1);
            chk("stall_hold_tag", 64'(otag), 64'd10);
            chk("stall_hold_lo", 64'(lo), 64'd15);
            chk("stall_hold_ready", 64'(ir), 64'd0);
        end
        ordy = 1'b1;
        #1;
        chk("stall_release_ready", 64'(ir), 64'd1);
        @(posedge clk); #1;
        iv = 1'b0;
        chk("stall_b_valid", 64'(ov), 64'd1);
        chk("stall_b_tag", 64'(otag), 64'd11);
        chk("stall_b_lo", 64'(lo), 64'd63);
        @(posedge clk); #1;
        chk("stall_c_valid", 64'(ov), 64'd1);
        chk("stall_c_tag", 64'(otag), 64'd12);
        chk("stall_c_lo", 64'(lo), 64'd20000);
        @(posedge clk); #1;
        chk("stall_empty", 64'(ov), 64'd0);

        // Reset with two operations in flight plus one presented during reset
        a = 32'd6; b = 32'd7; tag = 5'd20; mode = 2'b11; iv = 1'b1;
        @(posedge clk); #1;
        a = 32'hFFFF_FFF8; b = 32'd9; tag = 5'd21;
        @(posedge clk); #1;
        a = 32'd11; b = 32'd13; tag = 5'd22; reset = 1'b1;
        @(posedge clk); #1;
        chk("flush_valid", 64'(ov), 64'd0);
        chk("flush_lo", 64'(lo), 64'd0);
        chk("flush_hi", 64'(hi), 64'd0);
        chk("flush_tag", 64'(otag), 64'd0);
        reset = 1'b0; iv = 1'b0;
        #1;
        chk("flush_ready", 64'(ir), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("flush_no_ghost", 64'(ov), 64'd0);
        end

        // 16-bit randomized sweep against a sign-extended product model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s_iv = ($urandom_range(0, 3) != 0);
            s_a = 16'($urandom);
            s_b = 16'($urandom);
            s_mode = 2'($urandom);
            s_tag = 5'($urandom);
            s_ordy = ($urandom_range(0, 3) != 0);
            #1;
            if (s_ov && s_ordy) begin
                if (q.size() == 0) begin
                    chk("sweep_spurious", 64'd1, 64'd0);
                end else begin
                    front = q.pop_front();
                    chk("sweep_result", 64'({s_otag, s_hi, s_lo}), 64'(front));
                end
            end
            if (s_iv && s_ir) begin
                ea = s_mode[0] ? {{16{s_a[15]}}, s_a} : {16'h0, s_a};
                eb = (s_mode == 2'b11) ? {{16{s_b[15]}}, s_b} : {16'h0, s_b};
                p = ea * eb;
                q.push_back({s_tag, eh16(p[31:16]), p[15:0]});
            end
            @(posedge clk); #1;
        end
        s_iv = 1'b0;
        s_ordy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (s_ov) begin
                if (q.size() == 0) begin
                    chk("sweep_spurious", 64'd1, 64'd0);
                end else begin
                    front = q.pop_front();
                    chk("sweep_result", 64'({s_otag, s_hi, s_lo}), 64'(front));
                end
            end
            @(posedge clk); #1;
        end
        chk("sweep_drain", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
